rs_issue_scheduler: RTL and testbench

- Select/issue controller for the 64-entry reservation station.
- Each cycle, picks at most one ready entry per functional unit (FU0..FU2) using per-FU round-robin priority.
- Holds each pick in a registered valid/ready issue slot toward its FU, and pulses a per-entry clear back to the RS when the FU accepts.
- Sits between the RS storage array and the three execution units; owns no operand data, only entry indices.

---
 rtl/rs_issue_scheduler.sv | 125 ++++++++++++
 tb/tb_rs_issue_scheduler.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_issue_scheduler.sv
// rtl/rs_issue_scheduler.sv - per-FU round-robin select/issue controller for the reservation station
// Optional ISSUE_STATS_EN adds saturating per-FU accepted/stall counters.
module rs_issue_scheduler #(
  parameter int RS_SIZE = 64,
  parameter int IDX_W   = 6,
  parameter int NUM_FU  = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [RS_SIZE-1:0]        entry_ready,
  input  logic [2*RS_SIZE-1:0]      entry_fu,
  input  logic                      flush,
  input  logic [NUM_FU-1:0]         fu_ready,
  output logic [NUM_FU-1:0]         issue_valid,
  output logic [NUM_FU*IDX_W-1:0]   issue_idx,
  output logic [RS_SIZE-1:0]        entry_clear,
  output logic                      busy
`ifdef ISSUE_STATS_EN
  ,
  output logic [NUM_FU*32-1:0]      stat_issued,
  output logic [NUM_FU*32-1:0]      stat_stall
`endif
);

  logic [RS_SIZE-1:0]               in_flight, in_flight_nxt;
  logic [NUM_FU-1:0][IDX_W-1:0]     rr_ptr, rr_nxt;
  logic [NUM_FU-1:0][IDX_W-1:0]     idx_q, idx_nxt, cand_idx;
  logic [NUM_FU-1:0]                cand_found, accept, slot_free, valid_nxt;
  logic [RS_SIZE-1:0]               clear_nxt;
  logic [IDX_W-1:0]                 pos;

  always_comb begin
    for (int k = 0; k < NUM_FU; k++) begin
      accept[k]    = issue_valid[k] & fu_ready[k];
      slot_free[k] = ~issue_valid[k] | fu_ready[k];
    end
  end

  // Scan upward from each FU's pointer; index arithmetic wraps because RS_SIZE == 2**IDX_W.
  always_comb begin
    cand_found = '0;
    cand_idx   = '0;
    pos        = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      for (int off = 0; off < RS_SIZE; off++) begin
        pos = rr_ptr[k] + IDX_W'(off);
        if (!cand_found[k] && entry_ready[pos] && !in_flight[pos] &&
            entry_fu[2*pos +: 2] == 2'(k)) begin
          cand_found[k] = 1'b1;
          cand_idx[k]   = pos;
        end
      end
    end
  end

  always_comb begin
    in_flight_nxt = in_flight;
    clear_nxt     = '0;
    valid_nxt     = issue_valid;
    idx_nxt       = idx_q;
    rr_nxt        = rr_ptr;
    if (flush) begin
      valid_nxt     = '0;
      in_flight_nxt = '0;
    end else begin
      for (int k = 0; k < NUM_FU; k++) begin
        if (accept[k]) begin
          clear_nxt[idx_q[k]]     = 1'b1;
          in_flight_nxt[idx_q[k]] = 1'b0;
          rr_nxt[k]               = idx_q[k] + IDX_W'(1);
        end
        // A winner is never the entry just accepted: that one is still in flight during selection.
        if (slot_free[k]) begin
          valid_nxt[k] = cand_found[k];
          if (cand_found[k]) begin
            idx_nxt[k]                 = cand_idx[k];
            in_flight_nxt[cand_idx[k]] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issue_valid <= '0;
      idx_q       <= '0;
      entry_clear <= '0;
      in_flight   <= '0;
      rr_ptr      <= '0;
    end else begin
      issue_valid <= valid_nxt;
      idx_q       <= idx_nxt;
      entry_clear <= clear_nxt;
      in_flight   <= in_flight_nxt;
      rr_ptr      <= rr_nxt;
    end
  end

  assign issue_idx = idx_q;
  assign busy      = |issue_valid;

`ifdef ISSUE_STATS_EN
  logic [NUM_FU-1:0][31:0] issued_cnt, stall_cnt;

  // A flushed handshake is squashed, so it does not count as an acceptance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issued_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      for (int k = 0; k < NUM_FU; k++) begin
        if (accept[k] && !flush && issued_cnt[k] != 32'hFFFF_FFFF)
          issued_cnt[k] <= issued_cnt[k] + 32'd1;
        if (issue_valid[k] && !fu_ready[k] && stall_cnt[k] != 32'hFFFF_FFFF)
          stall_cnt[k] <= stall_cnt[k] + 32'd1;
      end
    end
  end

  assign stat_issued = issued_cnt;
  assign stat_stall  = stall_cnt;
`endif

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// tb/tb_rs_issue_scheduler.sv - directed and randomized checks of rs_issue_scheduler against a behavioural model
// Build with ISSUE_STATS_EN to also check the statistics counters.
module tb_rs_issue_scheduler;
  localparam int N  = 64;
  localparam int NF = 3;
  localparam int IW = 6;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    entry_ready;
  logic [2*N-1:0]  entry_fu;
  logic            flush;
  logic [NF-1:0]   fu_ready;
  logic [NF-1:0]   issue_valid;
  logic [NF*IW-1:0] issue_idx;
  logic [N-1:0]    entry_clear;
  logic            busy;
`ifdef ISSUE_STATS_EN
  logic [NF*32-1:0] stat_issued, stat_stall;
`endif

  rs_issue_scheduler dut (
    .clk(clk), .reset(reset), .entry_ready(entry_ready), .entry_fu(entry_fu),
    .flush(flush), .fu_ready(fu_ready), .issue_valid(issue_valid),
    .issue_idx(issue_idx), .entry_clear(entry_clear), .busy(busy)
`ifdef ISSUE_STATS_EN
    , .stat_issued(stat_issued), .stat_stall(stat_stall)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit           m_valid [NF];
  int           m_idx   [NF];
  int           m_rr    [NF];
  logic [N-1:0] m_inf;
  logic [N-1:0] m_clear;
  longint       m_issued[NF];
  longint       m_stall [NF];

  task automatic model_reset();
    for (int k = 0; k < NF; k++) begin
      m_valid[k] = 0; m_idx[k] = 0; m_rr[k] = 0; m_issued[k] = 0; m_stall[k] = 0;
    end
    m_inf   = '0;
    m_clear = '0;
  endtask

  task automatic model_edge();
    bit win_f[NF];
    int win[NF];
    bit free_slot;
    for (int k = 0; k < NF; k++) begin
      win_f[k] = 0; win[k] = 0;
      for (int off = 0; off < N; off++) begin
        int e;
        e = (m_rr[k] + off) % N;
        if (!win_f[k] && entry_ready[e] && !m_inf[e] && entry_fu[2*e +: 2] == 2'(k)) begin
          win_f[k] = 1; win[k] = e;
        end
      end
      if (m_valid[k] && !fu_ready[k]) m_stall[k]++;
      if (m_valid[k] && fu_ready[k] && !flush) m_issued[k]++;
    end
    m_clear = '0;
    if (flush) begin
      for (int k = 0; k < NF; k++) m_valid[k] = 0;
      m_inf = '0;
      return;
    end
    for (int k = 0; k < NF; k++) begin
      free_slot = !m_valid[k];
      if (m_valid[k] && fu_ready[k]) begin
        m_clear[m_idx[k]] = 1'b1;
        m_inf[m_idx[k]]   = 1'b0;
        m_rr[k]           = (m_idx[k] + 1) % N;
        free_slot         = 1;
      end
      if (free_slot) begin
        m_valid[k] = win_f[k];
        if (win_f[k]) begin
          m_idx[k]      = win[k];
          m_inf[win[k]] = 1'b1;
        end
      end
    end
  endtask

  // Advance one cycle; the RS frees an entry as soon as its clear pulse is seen.
  task automatic step();
    @(posedge clk);
    if (!reset) model_edge();
    #1;
    for (int i = 0; i < N; i++) if (m_clear[i]) entry_ready[i] = 1'b0;
  endtask

  task automatic raise(input int e, input int code);
    entry_ready[e]     = 1'b1;
    entry_fu[2*e +: 2] = 2'(code);
  endtask

  task automatic test_reset();
    reset = 1'b1; entry_ready = '0; entry_fu = '0; flush = 1'b0; fu_ready = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if (issue_valid !== 3'b000 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got valid=%b busy=%b want 000/0", issue_valid, busy);
    end
    n_checks++;
    if (issue_idx !== '0 || entry_clear !== '0) begin
      n_fail++; $display("FAIL reset_idx_clear: got idx=%h clear=%h want 0/0", issue_idx, entry_clear);
    end
  endtask

  task automatic test_single();
    fu_ready = 3'b111;
    raise(5, 1);
    step();
    n_checks++;
    if (issue_valid !== 3'b010 || issue_idx[IW +: IW] !== 6'd5) begin
      n_fail++; $display("FAIL single_issue: got valid=%b idx1=%0d want 010/5", issue_valid, issue_idx[IW +: IW]);
    end
    step();
    n_checks++;
    if (entry_clear !== 64'h20 || issue_valid !== 3'b000) begin
      n_fail++; $display("FAIL single_clear: got clear=%h valid=%b want 20/000", entry_clear, issue_valid);
    end
    // Pointer now 6: entry 7 wins over entry 3.
    raise(3, 1); raise(7, 1);
    step();
    n_checks++;
    if (issue_valid[1] !== 1'b1 || issue_idx[IW +: IW] !== 6'd7) begin
      n_fail++; $display("FAIL rr_after_single: got v1=%b idx1=%0d want 1/7", issue_valid[1], issue_idx[IW +: IW]);
    end
    step();
    n_checks++;
    if (issue_idx[IW +: IW] !== 6'd3 || entry_clear !== 64'h80) begin
      n_fail++; $display("FAIL rr_wrap1: got idx1=%0d clear=%h want 3/80", issue_idx[IW +: IW], entry_clear);
    end
    step();
  endtask

  task automatic test_round_robin();
    int exp_seq[5] = '{2, 10, 40, 2, 40};
    fu_ready = 3'b001;
    raise(2, 0); raise(10, 0); raise(40, 0);
    for (int s = 0; s < 5; s++) begin
      if (s == 3) begin raise(2, 0); raise(40, 0); end
      step();
      n_checks++;
      if (issue_valid[0] !== 1'b1 || issue_idx[0 +: IW] !== 6'(exp_seq[s])) begin
        n_fail++; $display("FAIL rr_order[%0d]: got v0=%b idx0=%0d want 1/%0d", s, issue_valid[0], issue_idx[0 +: IW], exp_seq[s]);
      end
      if (s == 2) begin
        step();
        n_checks++;
        if (issue_valid[0] !== 1'b0 || entry_clear !== (64'd1 << 40)) begin
          n_fail++; $display("FAIL rr_drain: got v0=%b clear=%h want 0/bit40", issue_valid[0], entry_clear);
        end
      end
    end
    step();
    step();
  endtask

  task automatic test_stall();
    fu_ready = 3'b000;
    raise(7, 2);
    step();
    for (int c = 0; c < 4; c++) begin
      step();
      n_checks++;
      if (issue_valid[2] !== 1'b1 || issue_idx[2*IW +: IW] !== 6'd7 || entry_clear !== '0) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got v2=%b idx2=%0d clear=%h want 1/7/0", c, issue_valid[2], issue_idx[2*IW +: IW], entry_clear);
      end
    end
    fu_ready = 3'b100;
    step();
    n_checks++;
    if (entry_clear !== 64'h80) begin
      n_fail++; $display("FAIL stall_release: got clear=%h want 80", entry_clear);
    end
    step();
    n_checks++;
    if (entry_clear !== '0) begin
      n_fail++; $display("FAIL stall_single_pulse: got clear=%h want 0", entry_clear);
    end
`ifdef ISSUE_STATS_EN
    n_checks++;
    if (stat_stall[64 +: 32] !== 32'd4 || stat_issued[64 +: 32] !== 32'd1) begin
      n_fail++; $display("FAIL stats_fu2: got stall=%0d issued=%0d want 4/1", stat_stall[64 +: 32], stat_issued[64 +: 32]);
    end
`endif
  endtask

  task automatic test_parallel();
    fu_ready = 3'b111;
    raise(1, 0); raise(2, 1); raise(3, 2);
    step();
    n_checks++;
    if (issue_valid !== 3'b111 || issue_idx !== {6'd3, 6'd2, 6'd1}) begin
      n_fail++; $display("FAIL parallel_issue: got valid=%b idx=%h want 111/{3,2,1}", issue_valid, issue_idx);
    end
    step();
    n_checks++;
    if (entry_clear !== 64'hE || busy !== 1'b0) begin
      n_fail++; $display("FAIL parallel_clear: got clear=%h busy=%b want e/0", entry_clear, busy);
    end
  endtask

  task automatic test_flush();
    fu_ready = 3'b000;
    raise(9, 0);
    step();
    flush = 1'b1; fu_ready = 3'b001;
    step();
    flush = 1'b0;
    n_checks++;
    if (issue_valid !== 3'b000 || entry_clear !== '0) begin
      n_fail++; $display("FAIL flush_drop: got valid=%b clear=%h want 000/0", issue_valid, entry_clear);
    end
    step();
    n_checks++;
    if (issue_valid[0] !== 1'b1 || issue_idx[0 +: IW] !== 6'd9) begin
      n_fail++; $display("FAIL flush_reissue: got v0=%b idx0=%0d want 1/9", issue_valid[0], issue_idx[0 +: IW]);
    end
    step();
    n_checks++;
    if (entry_clear !== (64'd1 << 9)) begin
      n_fail++; $display("FAIL flush_after_clear: got clear=%h want bit9", entry_clear);
    end
    step();
  endtask

  task automatic test_unassigned_and_reset();
    fu_ready = 3'b111;
    raise(4, 3);
    for (int c = 0; c < 4; c++) begin
      step();
      n_checks++;
      if (issue_valid !== 3'b000 || entry_clear !== '0) begin
        n_fail++; $display("FAIL unassigned[%0d]: got valid=%b clear=%h want 000/0", c, issue_valid, entry_clear);
      end
    end
    entry_ready = '0;
    fu_ready = 3'b000;
    raise(8, 1);
    step();
    fu_ready = 3'b010;
    #2 reset = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if (issue_valid !== 3'b000 || busy !== 1'b0 || issue_idx !== '0 || entry_clear !== '0) begin
      n_fail++; $display("FAIL async_reset: got valid=%b busy=%b idx=%h clear=%h want 0", issue_valid, busy, issue_idx, entry_clear);
    end
    entry_ready = '0;
    @(negedge clk);
    reset = 1'b0;
    step();
    n_checks++;
    if (entry_clear !== '0 || issue_valid !== 3'b000) begin
      n_fail++; $display("FAIL reset_no_clear: got clear=%h valid=%b want 0/000", entry_clear, issue_valid);
    end
  endtask

  task automatic test_random();
    int e;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int r = 0; r < 2; r++) begin
        e = int'($urandom_range(N - 1));
        if (!entry_ready[e]) raise(e, int'($urandom_range(3)));
      end
      if ($urandom_range(15) == 0) entry_ready[$urandom_range(N - 1)] = 1'b0;
      fu_ready = NF'($urandom);
      flush    = ($urandom_range(24) == 0);
      step();
      n_checks++;
      if (entry_clear !== m_clear) begin
        n_fail++; $display("FAIL rand_clear@%0d: got %h want %h", cyc, entry_clear, m_clear);
      end
      for (int k = 0; k < NF; k++) begin
        n_checks++;
        if (issue_valid[k] !== m_valid[k] ||
            (m_valid[k] && issue_idx[k*IW +: IW] !== 6'(m_idx[k]))) begin
          n_fail++; $display("FAIL rand_slot%0d@%0d: got v=%b idx=%0d want v=%b idx=%0d", k, cyc, issue_valid[k], issue_idx[k*IW +: IW], m_valid[k], m_idx[k]);
        end
      end
      n_checks++;
      if (busy !== (m_valid[0] | m_valid[1] | m_valid[2])) begin
        n_fail++; $display("FAIL rand_busy@%0d: got %b", cyc, busy);
      end
    end
    flush = 1'b0;
`ifdef ISSUE_STATS_EN
    for (int k = 0; k < NF; k++) begin
      n_checks++;
      if (stat_issued[k*32 +: 32] !== 32'(m_issued[k]) || stat_stall[k*32 +: 32] !== 32'(m_stall[k])) begin
        n_fail++; $display("FAIL rand_stats%0d: got issued=%0d stall=%0d want %0d/%0d", k, stat_issued[k*32 +: 32], stat_stall[k*32 +: 32], m_issued[k], m_stall[k]);
      end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_parallel();
    test_flush();
    test_unassigned_and_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
